// File: rtl/cache_lower_mem.sv
// cache_lower_mem: fixed-latency block memory serving cache refills and write-backs.
// Optional MEM_ABORT_EN: dropping Req_Low while BUSY abandons the access.
module cache_lower_mem #(
  parameter int ADDR_W  = 28,
  parameter int DEPTH_W = 10,
  parameter int BLOCK_W = 128,
  parameter int LATENCY = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Req_Low,
  input  logic               Wr_Low,
  input  logic [ADDR_W-1:0]  A_Low,
  input  logic [BLOCK_W-1:0] D_Low_In,
  output logic [BLOCK_W-1:0] D_Low_Out,
  output logic               Rdy_Low,
  output logic               Busy
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [DEPTH_W-1:0] idx_q, idx_d;
  logic wr_q, wr_d;
  logic [BLOCK_W-1:0] dat_q, dat_d, dout_q, dout_d;
  logic [BLOCK_W-1:0] mem [2**DEPTH_W];
  logic abort, accept, commit;
  logic unused_addr;
  assign unused_addr = ^A_Low[ADDR_W-1:DEPTH_W];
`ifdef MEM_ABORT_EN
  assign abort = !Req_Low;
`else
  assign abort = 1'b0;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  always_comb begin
    state_d = state_q == IDLE ? (Req_Low ? BUSY : IDLE)
            : state_q == BUSY ? (abort ? IDLE : cnt_q == 8'd0 ? DONE : BUSY)
            : IDLE;
  end
  assign accept = state_q == IDLE && Req_Low;
  assign commit = state_q == BUSY && state_d == DONE;
  always_comb begin
    cnt_d  = accept ? 8'(LATENCY - 1) : state_q == BUSY && cnt_q != 8'd0 ? cnt_q - 8'd1 : cnt_q;
    idx_d  = accept ? A_Low[DEPTH_W-1:0] : idx_q;
    wr_d   = accept ? Wr_Low : wr_q;
    dat_d  = accept ? D_Low_In : dat_q;
    dout_d = commit && !wr_q ? mem[idx_q] : dout_q;
  end
  always_ff @(posedge clk) begin
    idx_q <= idx_d;
    wr_q  <= wr_d;
    dat_q <= dat_d;
  end
  // a reset landing on the commit edge must not write the array
  always_ff @(posedge clk)
    if (!rst && commit && wr_q) mem[idx_q] <= dat_q;
  always_comb begin
    Rdy_Low   = state_q == DONE;
    Busy      = state_q != IDLE;
    D_Low_Out = dout_q;
  end
endmodule

// File: tb/tb_cache_lower_mem.sv
// tb_cache_lower_mem: vector table, corner sequences and random accesses against a block-array model.
module tb_cache_lower_mem;
  localparam int LAT = 4;
  localparam logic [127:0] K5 = 128'hDEAD_0000_0000_0000_0000_0000_0000_0005;
  localparam logic [127:0] K7 = 128'h7777_0000_AAAA_0000_5555_0000_CCCC_0007;
  localparam logic [127:0] K3 = 128'h3333_1234_5678_9ABC_DEF0_0000_0000_0003;
  localparam logic [127:0] K9 = 128'h9999_0000_0000_0000_0000_0000_0000_0009;
  localparam logic [127:0] K9N = 128'h9A9A_9A9A_0000_0000_0000_0000_0000_0009;
  localparam logic [127:0] KWB = 128'h1111_2222_3333_4444;
  logic clk = 1'b0;
  logic rst;
  logic req, wr, rdy, busy, req1, wr1, rdy1, busy1;
  logic [27:0] a, a1;
  logic [127:0] d, dout, d1, dout1;
  int n_chk = 0;
  int n_fail = 0;
  logic [127:0] ref_mem [1024];
  logic [127:0] last_rd;
  always #5 clk = ~clk;
  cache_lower_mem #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .Req_Low(req), .Wr_Low(wr), .A_Low(a), .D_Low_In(d),
    .D_Low_Out(dout), .Rdy_Low(rdy), .Busy(busy)
  );
  cache_lower_mem #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .Req_Low(req1), .Wr_Low(wr1), .A_Low(a1), .D_Low_In(d1),
    .D_Low_Out(dout1), .Rdy_Low(rdy1), .Busy(busy1)
  );
  typedef struct {
    logic         w;
    logic [27:0]  ad;
    logic [127:0] dt;
    logic [127:0] ex;
  } vec_t;
  vec_t tbl [7];
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] ex);
    n_chk++;
    if (act !== ex) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, ex);
    end
  endtask
  task automatic access(input logic w, input logic [27:0] ad, input logic [127:0] dt,
                        input logic [127:0] ex, input int exp_n, input logic hold, input string nm);
    int n = 0;
    int nb = 0;
    req = 1'b1; wr = w; a = ad; d = dt;
    do begin
      @(negedge clk);
      n++;
      nb += int'(busy);
    end while (!rdy && n < 40);
    chk({nm, " rdy cycle"}, 128'(n), 128'(exp_n));
    chk({nm, " busy cycles"}, 128'(nb), 128'(LAT + 1));
    if (w) ref_mem[ad[9:0]] = dt;
    else last_rd = ex;
    chk({nm, " dout"}, dout, last_rd);
    if (!hold) begin
      req = 1'b0;
      @(negedge clk);
      chk({nm, " rdy single"}, 128'(rdy), 128'(0));
    end
  endtask
  initial begin
    logic w, nh, hold;
    int idx, cnt, first;
    logic [127:0] dt;
    rst = 1'b1; req = 1'b0; wr = 1'b0; a = '0; d = '0;
    req1 = 1'b0; wr1 = 1'b0; a1 = '0; d1 = '0; last_rd = '0;
    repeat (3) @(negedge clk);
    chk("reset rdy", 128'(rdy), 128'(0));
    chk("reset busy", 128'(busy), 128'(0));
    chk("reset dout", dout, 128'(0));
    rst = 1'b0;
    @(negedge clk);
    tbl[0] = '{1'b1, 28'h000_0005, K5, '0};
    tbl[1] = '{1'b0, 28'h000_0005, '0, K5};
    tbl[2] = '{1'b1, 28'h040_0007, K7, '0};
    tbl[3] = '{1'b0, 28'h000_0007, '0, K7};
    tbl[4] = '{1'b1, 28'h000_0003, K3, '0};
    tbl[5] = '{1'b1, 28'h000_0009, K9, '0};
    tbl[6] = '{1'b0, 28'hFFF_FC09, '0, K9};
    for (int i = 0; i < 7; i++)
      access(tbl[i].w, tbl[i].ad, tbl[i].dt, tbl[i].ex, LAT + 1, 1'b0, $sformatf("vec%0d", i));
    access(1'b1, 28'h000_0012, KWB, '0, LAT + 1, 1'b1, "writeback");
    access(1'b0, 28'h000_0012, '0, KWB, LAT + 2, 1'b0, "refill");
    req = 1'b1; wr = 1'b1; a = 28'h000_0003; d = ~K3;
    repeat (2) @(negedge clk);
    rst = 1'b1; req = 1'b0;
    @(negedge clk);
    chk("midrst rdy", 128'(rdy), 128'(0));
    chk("midrst busy", 128'(busy), 128'(0));
    chk("midrst dout", dout, 128'(0));
    rst = 1'b0; last_rd = '0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      cnt += int'(rdy);
    end
    chk("midrst no rdy", 128'(cnt), 128'(0));
    access(1'b0, 28'h000_0003, '0, K3, LAT + 1, 1'b0, "midrst read3");
    req = 1'b1; wr = 1'b1; a = 28'h000_0009; d = K9N;
    repeat (2) @(negedge clk);
    req = 1'b0;
    cnt = 0; first = 0;
    for (int c = 3; c <= 10; c++) begin
      @(negedge clk);
      if (rdy) begin
        cnt++;
        if (first == 0) first = c;
      end
    end
`ifdef MEM_ABORT_EN
    chk("abort rdy count", 128'(cnt), 128'(0));
`else
    chk("noabort rdy count", 128'(cnt), 128'(1));
    chk("noabort rdy cycle", 128'(first), 128'(5));
    ref_mem[9] = K9N;
`endif
    access(1'b0, 28'h000_0009, '0, ref_mem[9], LAT + 1, 1'b0, "abort read9");
    req1 = 1'b1; wr1 = 1'b0; a1 = 28'h000_0005;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      chk($sformatf("lat1 rdy c%0d", c), 128'(rdy1), 128'(c == 2 || c == 5 || c == 8));
    end
    req1 = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++)
      access(1'b1, 28'(i), {$urandom, $urandom, $urandom, $urandom}, '0, LAT + 1, 1'b0, "init");
    hold = 1'b0;
    for (int i = 0; i < 150; i++) begin
      w = 1'($urandom_range(0, 1));
      idx = int'($urandom_range(0, 15));
      dt = {$urandom, $urandom, $urandom, $urandom};
      nh = i < 149 && $urandom_range(0, 2) == 0;
      access(w, {18'($urandom), 10'(idx)}, dt, ref_mem[idx], hold ? LAT + 2 : LAT + 1, nh,
             $sformatf("rand%0d", i));
      hold = nh;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
